// File: rtl/shape_ctrl_initiator.sv
// shape_ctrl_initiator: drives the shape processor CTRL SFR port.
// Each accepted request produces one SFR write, then one SFR read-back.
// The read-back is checked against the expected CTRL contents, and a status
// response is returned.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_shape/req_operation     requested field codes (KEEP codes allowed)
//   write/write_data            single-cycle SFR write strobe and CTRL word
//   read/read_data              single-cycle SFR read strobe and read-back word
//   error                       processor rejection flag (cycle after write)
//   rsp_valid/rsp_ready         response handshake
//   rsp_status                  {mismatch, rejected}
//   rsp_shape/rsp_operation     fields taken from the read-back word
module shape_ctrl_initiator #(
  parameter int unsigned SHAPE_LSB  = 0,
  parameter int unsigned SHAPE_W    = 3,
  parameter int unsigned OP_LSB     = 8,
  parameter int unsigned OP_W       = 4,
  parameter int unsigned KEEP_SHAPE = 7,
  parameter int unsigned KEEP_OP    = 15,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SHAPE_W-1:0] req_shape,
  input  logic [OP_W-1:0]    req_operation,
  output logic               write,
  output logic [31:0]        write_data,
  output logic               read,
  input  logic [31:0]        read_data,
  input  logic               error,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_status,
  output logic [SHAPE_W-1:0] rsp_shape,
  output logic [OP_W-1:0]    rsp_operation
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_ERRS, S_RD, S_WAIT, S_CHK, S_RSP
  } state_t;

  state_t             state, state_nxt;
  logic [SHAPE_W-1:0] req_shape_q, cache_shape_q;
  logic [OP_W-1:0]    req_op_q, cache_op_q;
  logic               cache_valid_q;
  logic               rej_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rd_q;

  logic               req_hs;
  logic [31:0]        wd_c;
  logic [SHAPE_W-1:0] rb_shape, exp_shape;
  logic [OP_W-1:0]    rb_op, exp_op;
  logic               shape_from_cache, op_from_cache;
  logic               shape_cmp, op_cmp, mis;

  assign req_hs = req_valid && req_ready;

  // Next state, handshake and read-back check
  always_comb begin
    state_nxt = state;
    wd_c      = 32'(req_shape) << SHAPE_LSB | 32'(req_operation) << OP_LSB;
    rb_shape  = rd_q[SHAPE_LSB +: SHAPE_W];
    rb_op     = rd_q[OP_LSB +: OP_W];

    // A rejected write or a KEEP code leaves the field at its previous value,
    // which is only known once a read-back has filled the cache.
    shape_from_cache = rej_q || (req_shape_q == SHAPE_W'(KEEP_SHAPE));
    op_from_cache    = rej_q || (req_op_q == OP_W'(KEEP_OP));
    exp_shape        = shape_from_cache ? cache_shape_q : req_shape_q;
    exp_op           = op_from_cache ? cache_op_q : req_op_q;
    shape_cmp        = !shape_from_cache || cache_valid_q;
    op_cmp           = !op_from_cache || cache_valid_q;
    mis              = (shape_cmp && (rb_shape != exp_shape)) ||
                       (op_cmp && (rb_op != exp_op));

    case (state)
      S_IDLE:  if (req_hs) state_nxt = S_WR;
      S_WR:    state_nxt = S_ERRS;
      S_ERRS:  state_nxt = S_RD;
      S_RD:    state_nxt = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_nxt = S_CHK;
      S_CHK:   state_nxt = S_RSP;
      S_RSP:   if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, registered outputs, datapath and cache
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      req_ready     <= 1'b0;
      write         <= 1'b0;
      write_data    <= '0;
      read          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_status    <= '0;
      rsp_shape     <= '0;
      rsp_operation <= '0;
      cache_valid_q <= 1'b0;
      cache_shape_q <= '0;
      cache_op_q    <= '0;
      req_shape_q   <= '0;
      req_op_q      <= '0;
      rej_q         <= 1'b0;
      cnt_q         <= '0;
      rd_q          <= '0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == S_IDLE);
      write     <= (state_nxt == S_WR);
      read      <= (state_nxt == S_RD);
      rsp_valid <= (state_nxt == S_RSP);

      if (state == S_IDLE && req_hs) begin
        req_shape_q <= req_shape;
        req_op_q    <= req_operation;
        write_data  <= wd_c;
      end

      if (state == S_ERRS) rej_q <= error;

      if (state == S_RD) cnt_q <= CNT_W'(RD_LAT - 1);

      if (state == S_WAIT) begin
        if (cnt_q == '0) rd_q  <= read_data;
        else             cnt_q <= cnt_q - CNT_W'(1);
      end

      if (state == S_CHK) begin
        rsp_status    <= {mis, rej_q};
        rsp_shape     <= rb_shape;
        rsp_operation <= rb_op;
        cache_shape_q <= rb_shape;
        cache_op_q    <= rb_op;
        cache_valid_q <= 1'b1;
      end
    end
  end

endmodule
